// File: rtl/coeff_token_decoder.sv
// Pipelined CAVLC coeff_token decoder: runtime-loaded VLC table per nC class
// plus a native 6-bit fixed-length path.
module coeff_token_decoder #(
    parameter int WIN_W    = 16,
    parameter int LZ_W     = 4,
    parameter int SUFFIX_W = 3,
    parameter int SEL_W    = 2,
    parameter int FLC_SEL  = 3
) (
    input  logic                            Clk,
    input  logic                            Rst,
    input  logic                            InValid,
    output logic                            InReady,
    input  logic [WIN_W-1:0]                Bits,
    input  logic [SEL_W-1:0]                TableSel,
    input  logic                            CfgWe,
    input  logic [SEL_W+LZ_W+SUFFIX_W-1:0]  CfgAddr,
    input  logic [12:0]                     CfgData,
    output logic                            OutValid,
    input  logic                            OutReady,
    output logic [4:0]                      TotalCoeff,
    output logic [1:0]                      TrailingOnes,
    output logic [4:0]                      CodeLen,
    output logic                            Error,
    output logic [7:0]                      ErrCount
);

    localparam int MAXZ  = 2**LZ_W - 1;
    localparam int AW    = SEL_W + LZ_W + SUFFIX_W;
    localparam int DEPTH = 2**AW;
    localparam logic [SEL_W-1:0] FLC = SEL_W'(FLC_SEL);

    logic advance;
    assign advance = !OutValid || OutReady;
    assign InReady = advance;

    logic [LZ_W-1:0]     lz;
    logic                noone;
    logic [WIN_W-1:0]    sh;
    logic [SUFFIX_W-1:0] suffix;
    logic [AW-1:0]       raddr;

    // Descending scan so the lowest leading-zero count wins.
    always_comb begin
        lz = LZ_W'(MAXZ);
        for (int i = MAXZ; i >= 0; i--) begin
            if (Bits[WIN_W-1-i]) lz = LZ_W'(i);
        end
        noone  = ~|Bits[WIN_W-1 -: MAXZ+1];
        sh     = (Bits << lz) << 1;
        suffix = sh[WIN_W-1 -: SUFFIX_W];
        raddr  = {TableSel, lz, suffix};
    end

    logic [12:0] mem [DEPTH];
    logic [12:0] ram_q;

    // Read-first: a same-address write lands after this cycle's read.
    always_ff @(posedge Clk) begin
        if (CfgWe) mem[CfgAddr] <= CfgData;
        if (advance) ram_q <= mem[raddr];
    end

    logic       s1_valid;
    logic       s1_noone;
    logic       s1_flc;
    logic [5:0] s1_fl;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            s1_valid <= 1'b0;
            s1_noone <= 1'b0;
            s1_flc   <= 1'b0;
            s1_fl    <= '0;
        end else if (advance) begin
            s1_valid <= InValid;
            s1_noone <= noone;
            s1_flc   <= (TableSel == FLC);
            s1_fl    <= Bits[WIN_W-1 -: 6];
        end
    end

    logic [3:0] fx;
    logic [1:0] fy;
    logic [4:0] tc_n;
    logic [1:0] t1_n;
    logic [4:0] len_n;
    logic       err_n;

    always_comb begin
        fx    = s1_fl[5:2];
        fy    = s1_fl[1:0];
        tc_n  = '0;
        t1_n  = '0;
        len_n = '0;
        err_n = 1'b0;
        if (s1_flc) begin
            len_n = 5'd6;
            if (s1_fl != 6'b000011) begin
                tc_n  = {1'b0, fx} + 5'd1;
                t1_n  = fy;
                err_n = ({3'b000, fy} > tc_n);
            end
        end else if (ram_q[12] && !s1_noone) begin
            tc_n  = ram_q[11:7];
            t1_n  = ram_q[6:5];
            len_n = ram_q[4:0];
        end else begin
            err_n = 1'b1;
        end
        if (s1_noone) err_n = 1'b1;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            OutValid     <= 1'b0;
            TotalCoeff   <= '0;
            TrailingOnes <= '0;
            CodeLen      <= '0;
            Error        <= 1'b0;
            ErrCount     <= '0;
        end else begin
            if (advance) begin
                OutValid <= s1_valid;
                if (s1_valid) begin
                    TotalCoeff   <= tc_n;
                    TrailingOnes <= t1_n;
                    CodeLen      <= len_n;
                    Error        <= err_n;
                end
            end
            if (OutValid && OutReady && Error && ErrCount != 8'hFF)
                ErrCount <= ErrCount + 8'd1;
        end
    end

endmodule

// File: tb/tb_coeff_token_decoder.sv
// Directed testbench for coeff_token_decoder.
module tb_coeff_token_decoder;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        InValid;
    logic        InReady;
    logic [15:0] Bits;
    logic [1:0]  TableSel;
    logic        CfgWe;
    logic [8:0]  CfgAddr;
    logic [12:0] CfgData;
    logic        OutValid;
    logic        OutReady;
    logic [4:0]  TotalCoeff;
    logic [1:0]  TrailingOnes;
    logic [4:0]  CodeLen;
    logic        Error;
    logic [7:0]  ErrCount;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    coeff_token_decoder dut (
        .Clk(Clk), .Rst(Rst),
        .InValid(InValid), .InReady(InReady),
        .Bits(Bits), .TableSel(TableSel),
        .CfgWe(CfgWe), .CfgAddr(CfgAddr), .CfgData(CfgData),
        .OutValid(OutValid), .OutReady(OutReady),
        .TotalCoeff(TotalCoeff), .TrailingOnes(TrailingOnes),
        .CodeLen(CodeLen), .Error(Error), .ErrCount(ErrCount)
    );

    // {OutValid, Error, TotalCoeff, TrailingOnes, CodeLen}
    function automatic logic [13:0] obs();
        return {OutValid, Error, TotalCoeff, TrailingOnes, CodeLen};
    endfunction

    function automatic logic [12:0] ent(input logic v, input logic [4:0] tc,
                                        input logic [1:0] t1, input logic [4:0] len);
        return {v, tc, t1, len};
    endfunction

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] sel, input logic [3:0] lz,
                             input logic [2:0] suf, input logic [12:0] d);
        CfgWe   = 1'b1;
        CfgAddr = {sel, lz, suf};
        CfgData = d;
        step();
        CfgWe   = 1'b0;
    endtask

    task automatic load_table();
        for (int s = 0; s < 8; s++) begin
            cfg_write(2'd0, 4'd0, 3'(s), ent(1'b1, 5'd0, 2'd0, 5'd1));
            cfg_write(2'd0, 4'd1, 3'(s), ent(1'b1, 5'd1, 2'd1, 5'd2));
            cfg_write(2'd0, 4'd2, 3'(s), ent(1'b1, 5'd2, 2'd2, 5'd3));
        end
    endtask

    task automatic test_reset();
        Rst = 1'b1; InValid = 1'b0; Bits = '0; TableSel = '0;
        CfgWe = 1'b0; CfgAddr = '0; CfgData = '0; OutReady = 1'b1;
        step(); step();
        checks++;
        if ({obs(), ErrCount} !== 22'd0) begin
            errors++;
            $display("FAIL reset_outs got %h exp 0", {obs(), ErrCount});
        end
        Rst = 1'b0;
        checks++;
        if (InReady !== 1'b1) begin
            errors++;
            $display("FAIL reset_inready got %b exp 1", InReady);
        end
    endtask

    task automatic test_back_to_back();
        TableSel = 2'd0; OutReady = 1'b1;
        InValid = 1'b1; Bits = 16'h8000;
        step();
        checks++;
        if (OutValid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_latency got %b exp 0", OutValid);
        end
        Bits = 16'h4000;
        step();
        checks++;
        if (obs() !== {1'b1, 1'b0, 5'd0, 2'd0, 5'd1}) begin
            errors++;
            $display("FAIL b2b_tok0 got %h exp %h", obs(), {1'b1, 1'b0, 5'd0, 2'd0, 5'd1});
        end
        Bits = 16'h2000;
        step();
        checks++;
        if (obs() !== {1'b1, 1'b0, 5'd1, 2'd1, 5'd2}) begin
            errors++;
            $display("FAIL b2b_tok1 got %h exp %h", obs(), {1'b1, 1'b0, 5'd1, 2'd1, 5'd2});
        end
        InValid = 1'b0;
        step();
        checks++;
        if (obs() !== {1'b1, 1'b0, 5'd2, 2'd2, 5'd3}) begin
            errors++;
            $display("FAIL b2b_tok2 got %h exp %h", obs(), {1'b1, 1'b0, 5'd2, 2'd2, 5'd3});
        end
        step();
        checks++;
        if (OutValid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain got %b exp 0", OutValid);
        end
    endtask

    task automatic test_stall();
        TableSel = 2'd0; OutReady = 1'b0;
        InValid = 1'b1; Bits = 16'h8000;
        step();
        Bits = 16'h4000;
        step();
        checks++;
        if ({obs(), InReady} !== {1'b1, 1'b0, 5'd0, 2'd0, 5'd1, 1'b0}) begin
            errors++;
            $display("FAIL stall_full got %h exp %h", {obs(), InReady},
                     {1'b1, 1'b0, 5'd0, 2'd0, 5'd1, 1'b0});
        end
        Bits = 16'h2000;
        step();
        checks++;
        if ({obs(), InReady} !== {1'b1, 1'b0, 5'd0, 2'd0, 5'd1, 1'b0}) begin
            errors++;
            $display("FAIL stall_hold1 got %h exp %h", {obs(), InReady},
                     {1'b1, 1'b0, 5'd0, 2'd0, 5'd1, 1'b0});
        end
        step();
        checks++;
        if ({obs(), InReady} !== {1'b1, 1'b0, 5'd0, 2'd0, 5'd1, 1'b0}) begin
            errors++;
            $display("FAIL stall_hold2 got %h exp %h", {obs(), InReady},
                     {1'b1, 1'b0, 5'd0, 2'd0, 5'd1, 1'b0});
        end
        OutReady = 1'b1;
        step();
        InValid = 1'b0;
        checks++;
        if (obs() !== {1'b1, 1'b0, 5'd1, 2'd1, 5'd2}) begin
            errors++;
            $display("FAIL stall_rel_tok1 got %h exp %h", obs(), {1'b1, 1'b0, 5'd1, 2'd1, 5'd2});
        end
        step();
        checks++;
        if (obs() !== {1'b1, 1'b0, 5'd2, 2'd2, 5'd3}) begin
            errors++;
            $display("FAIL stall_rel_tok2 got %h exp %h", obs(), {1'b1, 1'b0, 5'd2, 2'd2, 5'd3});
        end
        step();
        checks++;
        if (OutValid !== 1'b0) begin
            errors++;
            $display("FAIL stall_no_dup got %b exp 0", OutValid);
        end
    endtask

    task automatic test_flc();
        TableSel = 2'd3; OutReady = 1'b1;
        InValid = 1'b1; Bits = 16'h0C00;
        step();
        Bits = 16'h5800;
        step();
        checks++;
        if (obs() !== {1'b1, 1'b0, 5'd0, 2'd0, 5'd6}) begin
            errors++;
            $display("FAIL flc_000011 got %h exp %h", obs(), {1'b1, 1'b0, 5'd0, 2'd0, 5'd6});
        end
        Bits = 16'h0800;
        step();
        checks++;
        if (obs() !== {1'b1, 1'b0, 5'd6, 2'd2, 5'd6}) begin
            errors++;
            $display("FAIL flc_010110 got %h exp %h", obs(), {1'b1, 1'b0, 5'd6, 2'd2, 5'd6});
        end
        InValid = 1'b0;
        step();
        checks++;
        if ({OutValid, Error, CodeLen} !== {1'b1, 1'b1, 5'd6}) begin
            errors++;
            $display("FAIL flc_err got %h exp %h", {OutValid, Error, CodeLen}, {1'b1, 1'b1, 5'd6});
        end
        step();
        checks++;
        if (ErrCount !== 8'd1) begin
            errors++;
            $display("FAIL flc_errcount got %0d exp 1", ErrCount);
        end
    endtask

    task automatic test_errors();
        TableSel = 2'd0; OutReady = 1'b1;
        InValid = 1'b1; Bits = 16'h0000;
        step();
        InValid = 1'b0;
        step();
        checks++;
        if (obs() !== {1'b1, 1'b1, 5'd0, 2'd0, 5'd0}) begin
            errors++;
            $display("FAIL noone_err got %h exp %h", obs(), {1'b1, 1'b1, 5'd0, 2'd0, 5'd0});
        end
        step();
        checks++;
        if (ErrCount !== 8'd2) begin
            errors++;
            $display("FAIL noone_errcount got %0d exp 2", ErrCount);
        end
        cfg_write(2'd1, 4'd0, 3'd0, 13'h0FFF);
        TableSel = 2'd1; InValid = 1'b1; Bits = 16'h8000;
        step();
        InValid = 1'b0;
        step();
        checks++;
        if (obs() !== {1'b1, 1'b1, 5'd0, 2'd0, 5'd0}) begin
            errors++;
            $display("FAIL invalid_entry got %h exp %h", obs(), {1'b1, 1'b1, 5'd0, 2'd0, 5'd0});
        end
        step();
        checks++;
        if (ErrCount !== 8'd3) begin
            errors++;
            $display("FAIL invalid_errcount got %0d exp 3", ErrCount);
        end
        TableSel = 2'd0; Bits = 16'h0000; InValid = 1'b1;
        repeat (300) step();
        InValid = 1'b0;
        repeat (4) step();
        checks++;
        if (ErrCount !== 8'd255) begin
            errors++;
            $display("FAIL errcount_sat got %0d exp 255", ErrCount);
        end
    endtask

    task automatic test_collision();
        cfg_write(2'd2, 4'd0, 3'd0, ent(1'b1, 5'd3, 2'd1, 5'd4));
        TableSel = 2'd2; OutReady = 1'b1;
        InValid = 1'b1; Bits = 16'h8000;
        CfgWe = 1'b1; CfgAddr = {2'd2, 4'd0, 3'd0};
        CfgData = ent(1'b1, 5'd5, 2'd3, 5'd9);
        step();
        CfgWe = 1'b0;
        step();
        checks++;
        if (obs() !== {1'b1, 1'b0, 5'd3, 2'd1, 5'd4}) begin
            errors++;
            $display("FAIL coll_old got %h exp %h", obs(), {1'b1, 1'b0, 5'd3, 2'd1, 5'd4});
        end
        InValid = 1'b0;
        step();
        checks++;
        if (obs() !== {1'b1, 1'b0, 5'd5, 2'd3, 5'd9}) begin
            errors++;
            $display("FAIL coll_new got %h exp %h", obs(), {1'b1, 1'b0, 5'd5, 2'd3, 5'd9});
        end
        step();
    endtask

    task automatic test_midreset();
        TableSel = 2'd0; OutReady = 1'b1;
        InValid = 1'b1; Bits = 16'h4000;
        step();
        Bits = 16'h2000;
        step();
        Rst = 1'b1; InValid = 1'b0;
        step();
        Rst = 1'b0;
        checks++;
        if ({OutValid, ErrCount, InReady} !== {1'b0, 8'd0, 1'b1}) begin
            errors++;
            $display("FAIL midrst_clear got %h exp %h", {OutValid, ErrCount, InReady},
                     {1'b0, 8'd0, 1'b1});
        end
        step();
        checks++;
        if (OutValid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_discard got %b exp 0", OutValid);
        end
        InValid = 1'b1; Bits = 16'h2000;
        step();
        InValid = 1'b0;
        step();
        checks++;
        if (obs() !== {1'b1, 1'b0, 5'd2, 2'd2, 5'd3}) begin
            errors++;
            $display("FAIL midrst_table got %h exp %h", obs(), {1'b1, 1'b0, 5'd2, 2'd2, 5'd3});
        end
        step();
    endtask

    initial begin
        test_reset();
        load_table();
        test_back_to_back();
        test_stall();
        test_flc();
        test_errors();
        test_collision();
        test_midreset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
